peripheral_dbg_pu_riscv_ahb3_slave_mem: RTL and testbench

PERIPHERAL_DBG_PU_RISCV_AHB3_SLAVE_MEM -- requirements
Module: peripheral_dbg_pu_riscv_ahb3_slave_mem

---
 rtl/peripheral_dbg_pu_riscv_pkg.sv | 21 ++
 rtl/peripheral_dbg_pu_riscv_ahb3_strb.sv | 20 ++
 rtl/peripheral_dbg_pu_riscv_ahb3_slave_mem.sv | 130 +++++++++++++
 tb/tb_peripheral_dbg_pu_riscv_ahb3_slave_mem.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_dbg_pu_riscv_pkg.sv
// Shared AHB3 encodings, slave FSM states and address-check helper.
package peripheral_dbg_pu_riscv_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  // True when the byte address is not a multiple of the transfer size.
  function automatic logic addr_misaligned(logic [2:0] size, logic [2:0] lo);
    logic [3:0] m;
    m = (4'd1 << size) - 4'd1;
    return |({1'b0, lo} & m);
  endfunction

endpackage

// File: rtl/peripheral_dbg_pu_riscv_ahb3_strb.sv
// Byte-lane strobes for an AHB transfer of size hsize at byte offset addr_lo.
module peripheral_dbg_pu_riscv_ahb3_strb #(
  parameter  int DATA_WIDTH = 32,
  localparam int NUM_LANES  = DATA_WIDTH / 8,
  localparam int BOFF       = $clog2(NUM_LANES)
) (
  input  logic [2:0]           hsize,
  input  logic [BOFF-1:0]      addr_lo,
  output logic [NUM_LANES-1:0] strb
);

  // A lane is enabled when it sits in the same 2^hsize-aligned block as the address.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [BOFF-1:0] LANE = BOFF'(i);
    logic [BOFF-1:0] diff;
    assign diff    = LANE ^ addr_lo;
    assign strb[i] = ((diff >> hsize) == '0);
  end

endmodule

// File: rtl/peripheral_dbg_pu_riscv_ahb3_slave_mem.sv
// AHB3-lite memory slave with programmable wait states and two-cycle ERROR.
module peripheral_dbg_pu_riscv_ahb3_slave_mem
  import peripheral_dbg_pu_riscv_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int BOFF      = $clog2(NUM_LANES);
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [NUM_LANES-1:0][7:0] mem [MEM_DEPTH];

  state_t               state;
  logic [3:0]           wcnt;
  logic                 rdy, resp;
  logic                 d_act, d_write;
  logic [2:0]           d_size;
  logic [IDX_W-1:0]     d_idx;
  logic [BOFF-1:0]      d_lo;
  logic                 accept, err, we;
  logic [NUM_LANES-1:0] strb;

  logic unused_bus;
  assign unused_bus = ^{HBURST, HPROT, HMASTLOCK};

  assign accept = HSEL & HREADY & rdy &
                  ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign err    = ((HADDR >> (BOFF + IDX_W)) != '0) |
                  (HSIZE > 3'(BOFF)) |
                  addr_misaligned(HSIZE, HADDR[2:0]);

  // Final OKAY data-phase cycle commits the write; reset aborts it.
  assign we = d_act & d_write & rdy & (resp == HRESP_OKAY) & ~HRESET;

  assign HREADYOUT = rdy;
  assign HRESP     = resp;
  assign HRDATA    = (d_act & ~d_write & rdy & (resp == HRESP_OKAY) & ~HRESET)
                     ? mem[d_idx] : '0;

  peripheral_dbg_pu_riscv_ahb3_strb #(.DATA_WIDTH(DATA_WIDTH)) u_strb (
    .hsize   (d_size),
    .addr_lo (d_lo),
    .strb    (strb)
  );

  // Address-phase capture and data-phase response sequencing.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= IDLE;
      wcnt    <= '0;
      rdy     <= 1'b1;
      resp    <= HRESP_OKAY;
      d_act   <= 1'b0;
      d_write <= 1'b0;
      d_size  <= '0;
      d_idx   <= '0;
      d_lo    <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (wcnt == 4'd0) begin
            state <= IDLE;
            rdy   <= 1'b1;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        ERR1: begin
          state <= ERR2;
          rdy   <= 1'b1;
        end
        default: begin
          rdy   <= 1'b1;
          resp  <= HRESP_OKAY;
          d_act <= 1'b0;
          state <= IDLE;
          if (accept) begin
            d_write <= HWRITE;
            d_size  <= HSIZE;
            d_idx   <= HADDR[BOFF +: IDX_W];
            d_lo    <= HADDR[BOFF-1:0];
            if (err) begin
              state <= ERR1;
              rdy   <= 1'b0;
              resp  <= HRESP_ERROR;
            end else begin
              d_act <= 1'b1;
              if (WAIT_STATES > 0) begin
                state <= WAIT;
                rdy   <= 1'b0;
                wcnt  <= WS_M1;
              end
            end
          end
        end
      endcase
    end
  end

  // Byte-lane masked memory write; contents survive reset.
  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (strb[i]) mem[d_idx][i] <= HWDATA[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_peripheral_dbg_pu_riscv_ahb3_slave_mem.sv
// Directed bench: one zero-wait and one 3-wait-state slave on a shared clock.
module tb_peripheral_dbg_pu_riscv_ahb3_slave_mem;
  import peripheral_dbg_pu_riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             hreset;
  logic [1:0]       hsel, hwrite;
  logic [1:0][31:0] haddr, hwdata;
  logic [1:0][2:0]  hsize;
  logic [1:0][1:0]  htrans;
  logic [2:0]       hburst = 3'd0;
  logic [3:0]       hprot  = 4'd0;
  logic             hlock  = 1'b0;
  logic [31:0]      hrdata0, hrdata1;
  logic             hrdy0, hrdy1, hresp0, hresp1;

  int total = 0;
  int fails = 0;
  logic [31:0] rd;
  logic        rs;
  int          nl;

  peripheral_dbg_pu_riscv_ahb3_slave_mem #(.WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel[0]), .HADDR(haddr[0]),
    .HWDATA(hwdata[0]), .HRDATA(hrdata0), .HWRITE(hwrite[0]), .HSIZE(hsize[0]),
    .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans[0]), .HMASTLOCK(hlock),
    .HREADY(hrdy0), .HREADYOUT(hrdy0), .HRESP(hresp0)
  );

  peripheral_dbg_pu_riscv_ahb3_slave_mem #(.WAIT_STATES(3)) u_dut3 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel[1]), .HADDR(haddr[1]),
    .HWDATA(hwdata[1]), .HRDATA(hrdata1), .HWRITE(hwrite[1]), .HSIZE(hsize[1]),
    .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans[1]), .HMASTLOCK(hlock),
    .HREADY(hrdy1), .HREADYOUT(hrdy1), .HRESP(hresp1)
  );

  function automatic logic get_rdy(int b);
    return (b == 1) ? hrdy1 : hrdy0;
  endfunction
  function automatic logic get_resp(int b);
    return (b == 1) ? hresp1 : hresp0;
  endfunction
  function automatic logic [31:0] get_rdata(int b);
    return (b == 1) ? hrdata1 : hrdata0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic aphase(int b, logic wr, logic [2:0] sz, logic [31:0] a);
    hsel[b] = 1'b1; htrans[b] = HTRANS_NONSEQ; hwrite[b] = wr;
    hsize[b] = sz;  haddr[b] = a;
  endtask

  task automatic idle(int b);
    hsel[b] = 1'b0; htrans[b] = HTRANS_IDLE; hwrite[b] = 1'b0;
    hsize[b] = 3'd0; haddr[b] = 32'd0;
  endtask

  // One non-pipelined transfer; returns in its final data-phase cycle.
  task automatic xfer(int b, logic wr, logic [2:0] sz, logic [31:0] a, logic [31:0] wd,
                      output logic [31:0] rdata, output logic resp, output int nlow);
    aphase(b, wr, sz, a);
    tick();
    idle(b);
    hwdata[b] = wd;
    nlow = 0;
    for (int n = 0; n < 20 && get_rdy(b) !== 1'b1; n++) begin
      nlow++;
      tick();
    end
    chk("xfer_ready_bound", {31'd0, get_rdy(b)}, 32'd1);
    rdata = get_rdata(b);
    resp  = get_resp(b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    hreset = 1'b1;
    hwdata = '0;
    idle(0);
    idle(1);
    tick();
    tick();
    chk("rst_rdy0",   {31'd0, hrdy0},  32'd1);
    chk("rst_resp0",  {31'd0, hresp0}, 32'd0);
    chk("rst_rdata0", hrdata0,         32'd0);
    chk("rst_rdy1",   {31'd0, hrdy1},  32'd1);
    hreset = 1'b0;
    tick();

    // Back-to-back write then read of the same word, no wait states.
    aphase(0, 1'b1, 3'd2, 32'h10);
    tick();
    chk("b2b_wr_rdy", {31'd0, hrdy0}, 32'd1);
    hwdata[0] = 32'hDEADBEEF;
    aphase(0, 1'b0, 3'd2, 32'h10);
    tick();
    chk("b2b_rd_rdy",  {31'd0, hrdy0}, 32'd1);
    chk("b2b_rd_data", hrdata0, 32'hDEADBEEF);
    idle(0);
    tick();
    chk("idle_rdata", hrdata0, 32'd0);
    chk("idle_resp",  {31'd0, hresp0}, 32'd0);

    // Sub-word writes keep the other lanes.
    xfer(0, 1'b1, 3'd2, 32'h10, 32'h11223344, rd, rs, nl);
    xfer(0, 1'b1, 3'd0, 32'h13, 32'hAAAAAAAA, rd, rs, nl);
    xfer(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, rs, nl);
    chk("byte_wr",   rd, 32'hAA223344);
    chk("ws0_nolow", 32'(nl), 32'd0);
    xfer(0, 1'b1, 3'd1, 32'h10, 32'h55665566, rd, rs, nl);
    xfer(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, rs, nl);
    chk("half_wr", rd, 32'hAA225566);

    // Out-of-range read: ERR1 then ERR2.
    aphase(0, 1'b0, 3'd2, 32'h400);
    tick();
    chk("oor_e1_resp", {31'd0, hresp0}, 32'd1);
    chk("oor_e1_rdy",  {31'd0, hrdy0},  32'd0);
    chk("oor_e1_data", hrdata0, 32'd0);
    idle(0);
    tick();
    chk("oor_e2_resp", {31'd0, hresp0}, 32'd1);
    chk("oor_e2_rdy",  {31'd0, hrdy0},  32'd1);
    chk("oor_e2_data", hrdata0, 32'd0);
    tick();
    chk("oor_after_resp", {31'd0, hresp0}, 32'd0);

    // Misaligned halfword write errors and leaves memory alone.
    xfer(0, 1'b1, 3'd2, 32'h0, 32'h01020304, rd, rs, nl);
    aphase(0, 1'b1, 3'd1, 32'h01);
    tick();
    chk("mis_e1_resp", {31'd0, hresp0}, 32'd1);
    chk("mis_e1_rdy",  {31'd0, hrdy0},  32'd0);
    idle(0);
    hwdata[0] = 32'hFFFFFFFF;
    tick();
    chk("mis_e2_resp", {31'd0, hresp0}, 32'd1);
    chk("mis_e2_rdy",  {31'd0, hrdy0},  32'd1);
    xfer(0, 1'b0, 3'd2, 32'h0, 32'h0, rd, rs, nl);
    chk("mis_mem",  rd, 32'h01020304);
    chk("mis_okay", {31'd0, rs}, 32'd0);

    // Oversized transfer is an error.
    xfer(0, 1'b0, 3'd3, 32'h0, 32'h0, rd, rs, nl);
    chk("size_err_resp", {31'd0, rs}, 32'd1);
    chk("size_err_data", rd, 32'd0);

    // Three wait states; a held address phase is ignored until ready.
    aphase(1, 1'b1, 3'd2, 32'h0);
    tick();
    chk("ws3_w1", {31'd0, hrdy1}, 32'd0);
    hwdata[1] = 32'hCAFEF00D;
    aphase(1, 1'b0, 3'd2, 32'h0);
    tick();
    chk("ws3_w2", {31'd0, hrdy1}, 32'd0);
    tick();
    chk("ws3_w3", {31'd0, hrdy1}, 32'd0);
    tick();
    chk("ws3_w4", {31'd0, hrdy1}, 32'd1);
    tick();
    chk("ws3_r1",      {31'd0, hrdy1}, 32'd0);
    chk("ws3_r1_data", hrdata1, 32'd0);
    idle(1);
    tick();
    chk("ws3_r2", {31'd0, hrdy1}, 32'd0);
    tick();
    chk("ws3_r3", {31'd0, hrdy1}, 32'd0);
    tick();
    chk("ws3_r4",      {31'd0, hrdy1}, 32'd1);
    chk("ws3_r4_data", hrdata1, 32'hCAFEF00D);
    tick();
    chk("ws3_idle_data", hrdata1, 32'd0);

    // Reset during the wait phase of a write aborts it.
    xfer(1, 1'b1, 3'd2, 32'h4, 32'h0BADF00D, rd, rs, nl);
    chk("ws3_lows", 32'(nl), 32'd3);
    aphase(1, 1'b1, 3'd2, 32'h4);
    tick();
    chk("rmid_wait", {31'd0, hrdy1}, 32'd0);
    hreset = 1'b1;
    hwdata[1] = 32'hFFFFFFFF;
    idle(1);
    tick();
    chk("rmid_rdy",  {31'd0, hrdy1},  32'd1);
    chk("rmid_resp", {31'd0, hresp1}, 32'd0);
    hreset = 1'b0;
    tick();
    chk("rmid_rdy2", {31'd0, hrdy1}, 32'd1);
    xfer(1, 1'b0, 3'd2, 32'h4, 32'h0, rd, rs, nl);
    chk("rmid_mem", rd, 32'h0BADF00D);
    tick();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
